// File: rtl/common_dffram_1wnr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// common_dffram_1wnr : flop-based RAM, 1 lane-masked write port, N read ports
// Revision: 1.0
// ---------------------------------------------------------------------------
module common_dffram_1wnr #(
  parameter int RAM_DATA_WIDTH   = 8,
  parameter int RAM_ADDR_WIDTH   = 2,
  parameter int RAM_LANE_WIDTH   = 4,
  parameter int RAM_READ_PORTS   = 2,
  parameter int RAM_READ_LATENCY = 0,
  parameter int RAM_BYPASS       = 1,
  parameter logic [RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     we,
  input  logic [RAM_ADDR_WIDTH-1:0]                waddr,
  input  logic [RAM_DATA_WIDTH/RAM_LANE_WIDTH-1:0] wmask,
  input  logic [RAM_DATA_WIDTH-1:0]                din,
  input  logic                                     clear,
  input  logic [RAM_READ_PORTS-1:0]                re,
  input  logic [RAM_READ_PORTS*RAM_ADDR_WIDTH-1:0] raddr,
  output logic [RAM_READ_PORTS*RAM_DATA_WIDTH-1:0] dout,
  output logic [RAM_READ_PORTS-1:0]                dvalid
);

  localparam int DEPTH = 1 << RAM_ADDR_WIDTH;
  localparam int LANES = RAM_DATA_WIDTH / RAM_LANE_WIDTH;

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]          valid;
  logic [RAM_DATA_WIDTH-1:0] bit_mask;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign bit_mask[k*RAM_LANE_WIDTH +: RAM_LANE_WIDTH] = {RAM_LANE_WIDTH{wmask[k]}};
    end
  endgenerate

  // The per-bit write of valid[waddr] follows the clear so the write wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RAM_RESET_VALUE;
      end
      valid <= '0;
    end else begin
      if (clear) begin
        valid <= '0;
      end
      if (we) begin
        mem[waddr]   <= (mem[waddr] & ~bit_mask) | (din & bit_mask);
        valid[waddr] <= 1'b1;
      end
    end
  end

  generate
    for (genvar p = 0; p < RAM_READ_PORTS; p++) begin : g_read
      logic [RAM_ADDR_WIDTH-1:0] ra;
      logic                      hit;
      logic [RAM_DATA_WIDTH-1:0] rdata;
      logic                      rvalid;

      assign ra     = raddr[p*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
      assign hit    = (RAM_BYPASS != 0) && we && (waddr == ra);
      assign rdata  = hit ? ((mem[ra] & ~bit_mask) | (din & bit_mask)) : mem[ra];
      assign rvalid = hit | valid[ra];

      if (RAM_READ_LATENCY == 0) begin : g_comb
        logic unused_re;
        assign unused_re = re[p];
        assign dout[p*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] = rdata;
        assign dvalid[p]                                = rvalid;
      end else begin : g_reg
        logic [RAM_DATA_WIDTH-1:0] dout_q;
        logic                      dvalid_q;

        always_ff @(posedge clk) begin
          if (!reset) begin
            dout_q   <= RAM_RESET_VALUE;
            dvalid_q <= 1'b0;
          end else if (re[p]) begin
            dout_q   <= rdata;
            dvalid_q <= rvalid;
          end
        end

        assign dout[p*RAM_DATA_WIDTH +: RAM_DATA_WIDTH] = dout_q;
        assign dvalid[p]                                = dvalid_q;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_common_dffram_1wnr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_common_dffram_1wnr : four configurations (latency x bypass) vs. a model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_common_dffram_1wnr;

  logic        clk = 1'b0;
  logic        reset, we, clear;
  logic [1:0]  waddr, wmask, re;
  logic [7:0]  din;
  logic [3:0]  raddr;
  logic [15:0] dout_x   [4];
  logic [1:0]  dvalid_x [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Config g: latency = g/2, bypass = g%2.
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      common_dffram_1wnr #(
        .RAM_DATA_WIDTH  (8),
        .RAM_ADDR_WIDTH  (2),
        .RAM_LANE_WIDTH  (4),
        .RAM_READ_PORTS  (2),
        .RAM_READ_LATENCY(g / 2),
        .RAM_BYPASS      (g % 2),
        .RAM_RESET_VALUE (8'hA5)
      ) u_dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wmask (wmask),
        .din   (din),
        .clear (clear),
        .re    (re),
        .raddr (raddr),
        .dout  (dout_x[g]),
        .dvalid(dvalid_x[g])
      );
    end
  endgenerate

  logic [7:0] mem_m [4];
  logic [3:0] vld_m;
  logic [8:0] q_m [4][2];   // {valid, data} held by registered-read configs
  bit         model_ok = 1'b0;

  function automatic logic [8:0] eff(input int byp, input int p);
    logic [1:0] ra;
    logic [7:0] d;
    logic       v;
    ra = raddr[p*2 +: 2];
    d  = mem_m[ra];
    v  = vld_m[ra];
    if (byp != 0 && we && waddr == ra) begin
      for (int k = 0; k < 2; k++)
        if (wmask[k]) d[k*4 +: 4] = din[k*4 +: 4];
      v = 1'b1;
    end
    return {v, d};
  endfunction

  task automatic check_outputs();
    logic [8:0] obs, exp;
    for (int g = 0; g < 4; g++) begin
      for (int p = 0; p < 2; p++) begin
        exp = (g / 2 == 1) ? q_m[g][p] : eff(g % 2, p);
        obs = {dvalid_x[g][p], dout_x[g][p*8 +: 8]};
        checks++;
        assert (obs === exp) else begin
          errors++;
          $error("FAIL cfg%0d_port%0d: observed %h expected %h", g, p, obs, exp);
        end
      end
    end
  endtask

  task automatic update_model();
    if (!reset) begin
      for (int i = 0; i < 4; i++) mem_m[i] = 8'hA5;
      vld_m = '0;
      for (int g = 0; g < 4; g++)
        for (int p = 0; p < 2; p++) q_m[g][p] = {1'b0, 8'hA5};
      model_ok = 1'b1;
    end else begin
      for (int g = 2; g < 4; g++)
        for (int p = 0; p < 2; p++)
          if (re[p]) q_m[g][p] = eff(g % 2, p);
      if (clear) vld_m = '0;
      if (we) begin
        for (int k = 0; k < 2; k++)
          if (wmask[k]) mem_m[waddr][k*4 +: 4] = din[k*4 +: 4];
        vld_m[waddr] = 1'b1;
      end
    end
  endtask

  task automatic step(input logic rst_n, input logic w, input logic [1:0] wa,
                      input logic [1:0] wm, input logic [7:0] d, input logic clr,
                      input logic [1:0] r, input logic [1:0] ra1, input logic [1:0] ra0);
    reset = rst_n; we = w; waddr = wa; wmask = wm; din = d;
    clear = clr; re = r; raddr = {ra1, ra0};
    @(negedge clk);
    if (model_ok) check_outputs();
    update_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; clear = 1'b0; re = '0; waddr = '0; wmask = '0;
    din = '0; raddr = '0;
    @(posedge clk);
    #1;
    // Reset overriding a write/clear/read in the same cycle
    step(1'b0, 1'b1, 2'd1, 2'b11, 8'h12, 1'b1, 2'b11, 2'd1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd1, 2'd0);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd3, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd0, 2'd1);
    // Masked write
    step(1'b1, 1'b1, 2'd1, 2'b11, 8'hFF, 1'b0, 2'b11, 2'd1, 2'd2);
    step(1'b1, 1'b1, 2'd1, 2'b01, 8'h3C, 1'b0, 2'b11, 2'd1, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd1, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd2, 2'd1);
    // Same-cycle write/read of addr 3, then zero-mask write still validates
    step(1'b1, 1'b1, 2'd3, 2'b11, 8'h77, 1'b0, 2'b11, 2'd3, 2'd1);
    step(1'b1, 1'b1, 2'd0, 2'b00, 8'h99, 1'b0, 2'b11, 2'd3, 2'd0);
    step(1'b1, 1'b1, 2'd2, 2'b10, 8'h5A, 1'b0, 2'b11, 2'd0, 2'd2);
    // Clear colliding with a write to addr 0
    step(1'b1, 1'b1, 2'd0, 2'b11, 8'h0E, 1'b1, 2'b11, 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd2, 2'd3);
    // Registered read hold while entry 2 is rewritten
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b01, 2'd0, 2'd2);
    step(1'b1, 1'b1, 2'd2, 2'b11, 8'hC3, 1'b0, 2'b00, 2'd0, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b00, 2'd0, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b01, 2'd0, 2'd2);
    // Reset mid-operation
    step(1'b0, 1'b1, 2'd2, 2'b11, 8'hEE, 1'b1, 2'b11, 2'd2, 2'd2);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd2, 2'd3);
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b11, 2'd0, 2'd1);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0), 1'($urandom), 2'($urandom), 2'($urandom),
           8'($urandom), ($urandom_range(0, 7) == 0), 2'($urandom),
           2'($urandom), 2'($urandom));
    end
    step(1'b1, 1'b0, 2'd0, 2'b00, 8'h00, 1'b0, 2'b00, 2'd0, 2'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/common_dffram_1wnr.md
Name: common_dffram_1wnr

Overview:
- Parametrised DFF-based RAM with one write port and RAM_READ_PORTS independent read ports.
- Adds lane-masked writes, per-entry valid tracking with a single-cycle invalidate-all, selectable read latency of 0 or 1, and optional write-to-read bypass.
- Serves as the storage primitive for small register-file-like structures in the core: rename tables, TLB/BTB tag arrays, small queues.

Parameters:
- RAM_DATA_WIDTH, 8, data bits per entry; must be a multiple of RAM_LANE_WIDTH.
- RAM_ADDR_WIDTH, 2, address bits; depth = 2^RAM_ADDR_WIDTH.
- RAM_LANE_WIDTH, 4, bits per write-mask lane; lanes = RAM_DATA_WIDTH / RAM_LANE_WIDTH.
- RAM_READ_PORTS, 2, number of read ports; must be >= 1.
- RAM_READ_LATENCY, 0, 0 = combinational read, 1 = registered read.
- RAM_BYPASS, 1, 1 = a same-cycle write to the read address is visible on the read data.
- RAM_RESET_VALUE, all zeros, RAM_DATA_WIDTH-bit value loaded into every entry on reset.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- we, input, 1, write enable.
- waddr, input, RAM_ADDR_WIDTH, write address.
- wmask, input, lanes, per-lane write enable; lane k covers bits [k*RAM_LANE_WIDTH +: RAM_LANE_WIDTH].
- din, input, RAM_DATA_WIDTH, write data.
- clear, input, 1, invalidate all entries; data contents are unchanged.
- re, input, RAM_READ_PORTS, per-port read enable; used only when RAM_READ_LATENCY=1.
- raddr, input, RAM_READ_PORTS*RAM_ADDR_WIDTH, flattened read addresses; port p uses slice [p*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH].
- dout, output, RAM_READ_PORTS*RAM_DATA_WIDTH, flattened read data.
- dvalid, output, RAM_READ_PORTS, valid bit of the entry read.

Behaviour:
- Reset (reset=0 at a clock edge):
  - every entry loads RAM_RESET_VALUE;
  - every valid bit clears to 0;
  - with latency 1, each dout slice loads RAM_RESET_VALUE and dvalid loads 0.
  - Reset overrides we, clear and re in the same cycle.
- Write: at an edge with we=1, each lane of entry waddr whose wmask bit is 1 takes the corresponding din bits. Lanes with wmask=0 keep their old value.
- Valid bit: entry waddr becomes valid whenever we=1, even if wmask is all zeros.
- clear=1: every valid bit clears at the edge.
- clear and we together: all entries are invalidated except waddr, which is written and left valid (the write wins for that entry).
- Effective read value of port p (call it R):
  - start from entry raddr_p;
  - if RAM_BYPASS=1, we=1 and waddr==raddr_p, replace the masked lanes with din and force valid=1;
  - clear never affects R in the same cycle.
- RAM_READ_LATENCY=0:
  - dout_p = R and dvalid_p = valid of R, combinationally.
  - re is ignored.
  - With RAM_BYPASS=0 the read returns the pre-write contents.
- RAM_READ_LATENCY=1:
  - at an edge with re[p]=1, the dout_p/dvalid_p registers capture R, so the data appears one cycle later;
  - re[p]=0 holds the previous output.
  - With RAM_BYPASS=0 the captured value is the pre-write (read-old) contents.
- Read ports are independent: any number of ports may read the same address as each other or as the write.
- No read or write conflicts exist; there are no stalls and no handshake.
- Out-of-range addresses cannot occur because depth is a full power of two.

Test Plan:
1. Reset, then latency 0: with reset=0 for 1 cycle and RAM_RESET_VALUE=8'hA5, all ports read 8'hA5 with dvalid=0 at every address.
2. Masked write: write 8'hFF with mask 2'b11 to addr 1, then din=8'h3C with wmask=2'b01 to addr 1 → read addr 1 returns 8'hFC and dvalid=1; addr 2 still returns dvalid=0.
3. Bypass:
   - RAM_BYPASS=1, latency 0: we with waddr=3, din=8'h77, mask 2'b11, while port 1 reads addr 3 in the same cycle → dout_1=8'h77, dvalid_1=1 that cycle.
   - RAM_BYPASS=0: the same stimulus returns the old value.
4. Clear collision: all entries valid; in the same cycle assert clear=1 and we to addr 0 → next cycle addr 0 has dvalid=1 and entries 1..3 have dvalid=0, with data unchanged.
5. Latency 1:
   - re[0]=1 with raddr=2 at edge n → dout_0 shows entry 2 after edge n;
   - re[0]=0 at edge n+1 while entry 2 is rewritten → dout_0 holds the old value.
6. Reset mid-operation: reset=0 in the same cycle as we=1, clear=1 and re=2'b11 → the write is dropped, all entries equal RAM_RESET_VALUE, all valid bits are 0, and with latency 1 the outputs equal RAM_RESET_VALUE with dvalid=0.
